mem_bank: RTL and testbench

Single-bank memory responder on the receiving end of the `controller` command interface (`act`/`rd`/`wr` plus separate read/write row and column buses). It models row activation, an activation-to-column delay, column reads with fixed CAS latency, and column writes. It serves as the target for `controller` in system simulation and as the on-chip scratch store behind it.

---
 rtl/mem_bank.sv | 158 +++++++++++++++
 tb/tb_mem_bank.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank.sv
// mem_bank: single-bank memory responder with row activation, T_RCD wait and fixed CL read pipeline.
// Define MEM_BANK_AUTOCLOSE_EN to close an open row after IDLE_TMO cycles without column commands.
module mem_bank #(
  parameter int DATA_W   = 8,
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4,
  parameter int T_RCD    = 2,
  parameter int CL       = 2,
  parameter int IDLE_TMO = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                act,
  input  logic                rd,
  input  logic                wr,
  input  logic [7:0]          addr_row_w,
  input  logic [7:0]          addr_col_w,
  input  logic [7:0]          addr_row_r,
  input  logic [7:0]          addr_col_r,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                row_open,
  output logic [ROW_BITS-1:0] open_row,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, RCD, OPEN} state_t;

  localparam int ADDR_W = ROW_BITS + COL_BITS;
  localparam int DEPTH  = 1 << ADDR_W;

  if (T_RCD < 1 || T_RCD > 15) begin : g_bad_t_rcd
    $error("mem_bank: T_RCD must be 1..15");
  end
  if (CL < 1 || CL > 8) begin : g_bad_cl
    $error("mem_bank: CL must be 1..8");
  end
  if (IDLE_TMO < 1) begin : g_bad_idle_tmo
    $error("mem_bank: IDLE_TMO must be at least 1");
  end

  state_t              state, state_n;
  logic [3:0]          rcd_cnt, rcd_cnt_n;
  logic [7:0]          row_sel;
  logic                row_bad, col_r_bad, col_w_bad;
  logic                act_ok, rd_ok, wr_ok, err_n, idle_expired;
  logic [ADDR_W-1:0]   raddr, waddr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [CL-1:0]       rv_pipe;
  logic [DATA_W-1:0]   rd_pipe [CL];

  // A read on the act cycle only steers the row bus; it never issues a column read.
  assign row_sel   = rd ? addr_row_r : addr_row_w;
  assign row_bad   = (row_sel >> ROW_BITS) != 8'd0;
  assign col_r_bad = (addr_col_r >> COL_BITS) != 8'd0;
  assign col_w_bad = (addr_col_w >> COL_BITS) != 8'd0;

  assign act_ok = act && !row_bad;
  assign rd_ok  = !act && rd && !wr && (state == OPEN) && !col_r_bad;
  assign wr_ok  = !act && wr && !rd && (state == OPEN) && !col_w_bad;
  assign err_n  = (act && row_bad) ||
                  (!act && (rd || wr) &&
                   ((state != OPEN) || (rd && wr) || (rd && col_r_bad) || (wr && col_w_bad)));

  assign raddr = {open_row, addr_col_r[COL_BITS-1:0]};
  assign waddr = {open_row, addr_col_w[COL_BITS-1:0]};

`ifdef MEM_BANK_AUTOCLOSE_EN
  localparam int TMO_W = $clog2(IDLE_TMO + 1);
  logic [TMO_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != OPEN || rd_ok || wr_ok || act_ok) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TMO_W'(1);
    end
  end

  assign idle_expired = (state == OPEN) && !(rd_ok || wr_ok || act_ok) &&
                        (idle_cnt == TMO_W'(IDLE_TMO - 1));
`else
  assign idle_expired = 1'b0;
`endif

  // An accepted act always wins: it restarts RCD from any state with the new row.
  always_comb begin
    state_n   = state;
    rcd_cnt_n = rcd_cnt;
    if (act_ok) begin
      state_n   = RCD;
      rcd_cnt_n = 4'(T_RCD - 1);
    end else begin
      case (state)
        RCD: begin
          if (rcd_cnt == 4'd0) begin
            state_n = OPEN;
          end else begin
            rcd_cnt_n = rcd_cnt - 4'd1;
          end
        end
        OPEN: begin
          if (idle_expired) begin
            state_n = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rcd_cnt  <= 4'd0;
      open_row <= '0;
      err      <= 1'b0;
    end else begin
      state   <= state_n;
      rcd_cnt <= rcd_cnt_n;
      err     <= err_n;
      if (act_ok) begin
        open_row <= row_sel[ROW_BITS-1:0];
      end
    end
  end

  // Storage deliberately has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rv_pipe <= '0;
      for (int i = 0; i < CL; i++) begin
        rd_pipe[i] <= '0;
      end
    end else begin
      rv_pipe[0] <= rd_ok;
      if (rd_ok) begin
        rd_pipe[0] <= mem[raddr];
      end
      for (int i = 1; i < CL; i++) begin
        rv_pipe[i] <= rv_pipe[i-1];
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign rvalid   = rv_pipe[CL-1];
  assign rdata    = rd_pipe[CL-1];
  assign row_open = (state == OPEN);

endmodule

// File: tb/tb_mem_bank.sv
// tb_mem_bank: self-checking bench for mem_bank; read expectations go through a scoreboard queue
// that a negedge monitor pops when rvalid appears, checking both cycle and data.
module tb_mem_bank;

  localparam int DATA_W   = 8;
  localparam int ROW_BITS = 4;
  localparam int COL_BITS = 4;
  localparam int T_RCD    = 2;
  localparam int CL       = 2;
  localparam int IDLE_TMO = 16;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                act, rd, wr;
  logic [7:0]          addr_row_w, addr_col_w, addr_row_r, addr_col_r;
  logic [DATA_W-1:0]   wdata, rdata;
  logic                rvalid, row_open, err;
  logic [ROW_BITS-1:0] open_row;

  int      cyc = 0;
  int      n_checks = 0;
  int      n_fail = 0;
  bit      mon_en = 1'b0;
  rd_exp_t sb[$];

  mem_bank #(
    .DATA_W(DATA_W), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS),
    .T_RCD(T_RCD), .CL(CL), .IDLE_TMO(IDLE_TMO)
  ) dut (
    .clk(clk), .rst(rst), .act(act), .rd(rd), .wr(wr),
    .addr_row_w(addr_row_w), .addr_col_w(addr_col_w),
    .addr_row_r(addr_row_r), .addr_col_r(addr_col_r),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .row_open(row_open), .open_row(open_row), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Inputs change on the falling edge so the next rising edge samples them cleanly.
  task automatic applyStimulus(input logic a, input logic r, input logic w,
                               input logic [7:0] row_w, input logic [7:0] col_w,
                               input logic [7:0] row_r, input logic [7:0] col_r,
                               input logic [DATA_W-1:0] dat);
    @(negedge clk);
    act = a; rd = r; wr = w;
    addr_row_w = row_w; addr_col_w = col_w;
    addr_row_r = row_r; addr_col_r = col_r;
    wdata = dat;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, '0);
  endtask

  task automatic writeCol(input logic [7:0] col, input logic [DATA_W-1:0] dat);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, col, 8'h00, 8'h00, dat);
  endtask

  task automatic readCol(input logic [7:0] col, input logic [DATA_W-1:0] expected);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, col, '0);
    sb.push_back('{due: cyc + CL, data: expected});
  endtask

  // The unused row bus carries an out-of-range row so picking the wrong bus shows up.
  task automatic openRow(input logic [7:0] row, input logic use_rd_bus);
    if (use_rd_bus) applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, row, 8'h00, '0);
    else            applyStimulus(1'b1, 1'b0, 1'b0, row, 8'h00, 8'hFF, 8'h00, '0);
    for (int i = 1; i <= T_RCD; i++) begin
      idleCycle();
      checkOutput("row_open_in_rcd", 32'(row_open), 32'd0);
      if (i == 1) checkOutput("open_row_on_act", 32'(open_row), 32'(row));
    end
    idleCycle();
    checkOutput("row_open_after_rcd", 32'(row_open), 32'd1);
    checkOutput("open_row_after_rcd", 32'(open_row), 32'(row));
    checkOutput("err_after_act", 32'(err), 32'd0);
  endtask

  task automatic checkErrPulse(input string tag);
    idleCycle();
    checkOutput({tag, "_err_high"}, 32'(err), 32'd1);
    idleCycle();
    checkOutput({tag, "_err_low"}, 32'(err), 32'd0);
  endtask

  // Monitor pops one expectation per rvalid and flags reads that never arrive.
  always @(negedge clk) begin
    rd_exp_t e;
    if (mon_en) begin
      if (rvalid !== 1'b0) begin
        if (sb.size() == 0) begin
          checkOutput("rvalid_spurious", 32'(rvalid), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rvalid_cycle", 32'(cyc), 32'(e.due));
          checkOutput("rdata", 32'(rdata), 32'(e.data));
        end
      end else if (sb.size() != 0 && cyc >= sb[0].due) begin
        e = sb.pop_front();
        checkOutput("rvalid_missing", 32'(rvalid), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: bench did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    act = 1'b0; rd = 1'b0; wr = 1'b0;
    addr_row_w = '0; addr_col_w = '0; addr_row_r = '0; addr_col_r = '0;
    wdata = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_row_open", 32'(row_open), 32'd0);
    checkOutput("reset_open_row", 32'(open_row), 32'd0);
    checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
    checkOutput("reset_rdata", 32'(rdata), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h05, '0);
    checkErrPulse("rd_idle");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h05, 8'h00, 8'h00, 8'hEE);
    checkErrPulse("wr_idle");

    openRow(8'd3, 1'b0);
    writeCol(8'd5, 8'hA5);
    readCol(8'd5, 8'hA5);
    idleCycle();
    checkOutput("err_after_legal", 32'(err), 32'd0);

    writeCol(8'd0, 8'h10);
    writeCol(8'd1, 8'h11);
    writeCol(8'd2, 8'h12);
    readCol(8'd0, 8'h10);
    readCol(8'd1, 8'h11);
    readCol(8'd2, 8'h12);
    repeat (CL + 1) idleCycle();

    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 8'h05, 8'h00, 8'h05, 8'h33);
    checkErrPulse("rd_wr_open");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h15, '0);
    checkErrPulse("col_r_high");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h25, 8'h00, 8'h00, 8'h77);
    checkErrPulse("col_w_high");
    readCol(8'd5, 8'hA5);

    applyStimulus(1'b1, 1'b1, 1'b0, 8'h03, 8'h00, 8'h10, 8'h00, '0);
    idleCycle();
    checkOutput("bad_row_err_high", 32'(err), 32'd1);
    checkOutput("bad_row_keeps_open", 32'(row_open), 32'd1);
    checkOutput("bad_row_keeps_row", 32'(open_row), 32'd3);
    idleCycle();
    checkOutput("bad_row_err_low", 32'(err), 32'd0);
    checkOutput("bad_row_still_open", 32'(row_open), 32'd1);
    readCol(8'd5, 8'hA5);

    applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h07, 8'h00, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h05, '0);
    idleCycle();
    checkOutput("rd_rcd_err_high", 32'(err), 32'd1);
    checkOutput("rd_rcd_row_closed", 32'(row_open), 32'd0);
    checkOutput("rd_rcd_open_row", 32'(open_row), 32'd7);
    idleCycle();
    checkOutput("rd_rcd_err_low", 32'(err), 32'd0);
    checkOutput("rd_rcd_row_open", 32'(row_open), 32'd1);

    writeCol(8'd5, 8'h5A);
    readCol(8'd5, 8'h5A);
    openRow(8'd3, 1'b0);
    readCol(8'd5, 8'hA5);
    openRow(8'd7, 1'b1);
    readCol(8'd5, 8'h5A);
    repeat (CL + 1) idleCycle();

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h05, '0);
    @(negedge clk);
    act = 1'b0; rd = 1'b0; wr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midread_rvalid", 32'(rvalid), 32'd0);
    checkOutput("midread_row_open", 32'(row_open), 32'd0);
    checkOutput("midread_open_row", 32'(open_row), 32'd0);
    repeat (CL + 1) idleCycle();

    openRow(8'd3, 1'b0);
    readCol(8'd5, 8'hA5);
    repeat (IDLE_TMO + 4) idleCycle();
`ifdef MEM_BANK_AUTOCLOSE_EN
    checkOutput("autoclose_row_open", 32'(row_open), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h05, '0);
    checkErrPulse("rd_after_autoclose");
`else
    checkOutput("no_autoclose_row_open", 32'(row_open), 32'd1);
    readCol(8'd5, 8'hA5);
`endif

    repeat (CL + 3) idleCycle();
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
